btn_event: RTL and testbench
============================

Name: btn_event

Overview:
- Consumes the debounced level `in` from the debounce controller (same clock, already glitch-free) and turns it into discrete user events.
- Events: single-cycle press and release pulses, a long-press pulse, and auto-repeat pulses while the button stays held.
- Keeps a 4-digit BCD event counter for the seven-segment display stage downstream.

Parameters:
- LONG_CYCLES, default 50000000, hold cycles after the press edge before long_press fires (>=2).
- REPEAT_CYCLES, default 12500000, cycles between successive rpt pulses once long (>=2).

Ports:
- clk  input  1  system clock, rising edge.
- r_n  input  1  reset; asynchronous, active-low.
- in  input  1  debounced level (1 = pressed), synchronous to clk.
- clr  input  1  synchronous clear of count.
- press  output  1  one-cycle pulse on press.
- release  output  1  one-cycle pulse on release.
- long_press  output  1  one-cycle pulse when hold reaches LONG_CYCLES.
- rpt  output  1  one-cycle auto-repeat pulse.
- held  output  1  state != IDLE.
- is_long  output  1  state == LONG.
- count  output  16  BCD count, 4 digits, [15:12] thousands … [3:0] units.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset (r_n=0, immediate, no clock needed):
  - state=IDLE, hcnt=0, count=16'h0000.
  - All pulse outputs, held and is_long are 0.
  - Reset mid-hold drops everything. After reset release with in already 1, the first edge produces press (treated as a new press).
- All outputs are registered. Pulses are high for exactly one cycle following the edge that generates them.
- hcnt: hold counter, width clog2(max(LONG_CYCLES, REPEAT_CYCLES)).
- FSM states IDLE, PRESSED, LONG. Transitions at each rising edge:
  - IDLE, in=1 -> PRESSED; press=1; hcnt<=0; count increments.
  - IDLE, in=0 -> stay IDLE.
  - PRESSED, in=0 -> IDLE; release=1; hcnt<=0.
  - PRESSED, in=1, hcnt==LONG_CYCLES-1 -> LONG; long_press=1; hcnt<=0.
  - PRESSED, in=1 otherwise -> hcnt+1.
  - LONG, in=0 -> IDLE; release=1; hcnt<=0.
  - LONG, in=1, hcnt==REPEAT_CYCLES-1 -> rpt=1; count increments; hcnt<=0.
  - LONG, in=1 otherwise -> hcnt+1.
  - Illegal state encoding -> IDLE, all outputs 0.
- Timing: let E0 be the edge that samples in=1 in IDLE.
  - long_press follows edge E0+LONG_CYCLES.
  - rpt follows edges E0+LONG_CYCLES+k·REPEAT_CYCLES, k>=1.
- Simultaneous events:
  - in=0 on the threshold edge: release wins; no long_press or rpt is issued.
  - clr on the same edge as an increment: clr wins, count=0000.
- long_press does not increment count; only press and rpt do.
- BCD arithmetic:
  - Units digit 9 -> 0 with carry into the next digit.
  - 9999 -> 0000 (wrap, no saturation).
  - Digits never take values A–F.
- One-cycle in pulse (1 then 0): press after E0, release after E0+1. held is high for exactly one cycle.

Test Plan (LONG_CYCLES=8, REPEAT_CYCLES=4):
1. Reset: r_n=0 asynchronously mid-cycle while held in LONG -> outputs 0 and count=0000 immediately, before the next clk edge.
2. Short press: in high 3 cycles then low -> press pulse after E0, release pulse after E0+3, count=0001, long_press never asserted.
3. Long hold: in high 20 cycles -> long_press after E0+8, rpt after E0+12 and E0+16, release after E0+20, count=0003, is_long high from E0+8 to E0+20.
4. Boundary: in falls exactly at E0+8 -> release only, no long_press, is_long stays 0, count=0001.
5. BCD wrap: preload via 9999 presses (or forced) -> next press gives count=0000. From 0009 -> 0010. From 0099 -> 0100.
6. Clear collision: clr=1 on the press edge -> count=0000 and the press pulse is still emitted. clr alone while idle -> count=0000.

Source files
------------

// File: rtl/btn_event_if.sv
`default_nettype none
// ============================================================================
//  Module      : btn_event_if
//  Description : Signal bundle between a button-event consumer and the
//                btn_event block. The master drives the debounced level and
//                the count clear; the slave (btn_event) returns the event
//                pulses, hold status and the BCD event count.
//  Signals     : i_in         debounced level, 1 = pressed
//                i_clr        synchronous clear of the event count
//                o_press      one-cycle press pulse
//                o_release    one-cycle release pulse
//                o_long_press one-cycle pulse when the hold becomes long
//                o_rpt        one-cycle auto-repeat pulse
//                o_held       button is being held (any non-idle state)
//                o_is_long    hold has passed the long-press threshold
//                o_count      4-digit BCD event count
//  Revision    : 1.0 - initial release
// ============================================================================
interface btn_event_if;
  logic        i_in;
  logic        i_clr;
  logic        o_press;
  logic        o_release;
  logic        o_long_press;
  logic        o_rpt;
  logic        o_held;
  logic        o_is_long;
  logic [15:0] o_count;

  modport master (
    output i_in, i_clr,
    input  o_press, o_release, o_long_press, o_rpt, o_held, o_is_long, o_count
  );

  modport slave (
    input  i_in, i_clr,
    output o_press, o_release, o_long_press, o_rpt, o_held, o_is_long, o_count
  );
endinterface
`default_nettype wire

// File: rtl/btn_event.sv
`default_nettype none
// ============================================================================
//  Module      : btn_event
//  Description : Turns a debounced button level into discrete events: press
//                and release pulses, a long-press pulse after LONG_CYCLES of
//                hold, and auto-repeat pulses every REPEAT_CYCLES afterwards.
//                Press and repeat events advance a 4-digit BCD counter.
//  Ports       : clk  system clock, rising edge
//                r_n  asynchronous active-low reset
//                bus  btn_event_if slave modport (level/clear in, events out)
//  Parameters  : LONG_CYCLES   hold cycles after the press edge before the
//                              long-press pulse (>= 2)
//                REPEAT_CYCLES cycles between repeat pulses once long (>= 2)
//  Revision    : 1.0 - initial release
// ============================================================================
module btn_event #(
  parameter int LONG_CYCLES   = 50000000,
  parameter int REPEAT_CYCLES = 12500000
) (
  input  wire logic    clk,
  input  wire logic    r_n,
  btn_event_if.slave   bus
);

  localparam int c_MAX_CYC = (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;
  localparam int c_HW      = (c_MAX_CYC > 1) ? $clog2(c_MAX_CYC) : 1;

  localparam logic [c_HW-1:0] c_LONG_LAST = c_HW'(LONG_CYCLES - 1);
  localparam logic [c_HW-1:0] c_RPT_LAST  = c_HW'(REPEAT_CYCLES - 1);
  localparam logic [c_HW-1:0] c_HONE      = c_HW'(1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PRESSED = 2'd1,
    S_LONG    = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [c_HW-1:0] r_hcnt;
  logic [c_HW-1:0] w_hcnt_nxt;

  logic            r_press,      w_press_nxt;
  logic            r_release,    w_release_nxt;
  logic            r_long_press, w_long_nxt;
  logic            r_rpt,        w_rpt_nxt;
  logic            r_held;
  logic            r_is_long;
  logic            w_inc;
  logic [15:0]     r_count;
  logic [15:0]     w_count_nxt;

  // Ripple BCD increment; any digit at 9 (or an impossible A-F) rolls to 0
  // and carries, so 9999 wraps to 0000.
  function automatic logic [15:0] f_bcd_inc(input logic [15:0] v);
    logic [15:0] res;
    logic        carry;
    res   = v;
    carry = 1'b1;
    for (int d = 0; d < 4; d++) begin
      if (carry) begin
        if (v[d*4 +: 4] >= 4'd9) begin
          res[d*4 +: 4] = 4'd0;
        end else begin
          res[d*4 +: 4] = v[d*4 +: 4] + 4'd1;
          carry         = 1'b0;
        end
      end
    end
    return res;
  endfunction

  // Next-state and event decode. Release always takes priority over the
  // threshold checks because in=0 is tested first in every held state.
  always_comb begin
    w_state_nxt   = r_state;
    w_hcnt_nxt    = r_hcnt;
    w_press_nxt   = 1'b0;
    w_release_nxt = 1'b0;
    w_long_nxt    = 1'b0;
    w_rpt_nxt     = 1'b0;
    w_inc         = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.i_in) begin
          w_state_nxt = S_PRESSED;
          w_press_nxt = 1'b1;
          w_hcnt_nxt  = '0;
          w_inc       = 1'b1;
        end
      end
      S_PRESSED: begin
        if (!bus.i_in) begin
          w_state_nxt   = S_IDLE;
          w_release_nxt = 1'b1;
          w_hcnt_nxt    = '0;
        end else if (r_hcnt == c_LONG_LAST) begin
          w_state_nxt = S_LONG;
          w_long_nxt  = 1'b1;
          w_hcnt_nxt  = '0;
        end else begin
          w_hcnt_nxt = r_hcnt + c_HONE;
        end
      end
      S_LONG: begin
        if (!bus.i_in) begin
          w_state_nxt   = S_IDLE;
          w_release_nxt = 1'b1;
          w_hcnt_nxt    = '0;
        end else if (r_hcnt == c_RPT_LAST) begin
          w_rpt_nxt  = 1'b1;
          w_inc      = 1'b1;
          w_hcnt_nxt = '0;
        end else begin
          w_hcnt_nxt = r_hcnt + c_HONE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_hcnt_nxt  = '0;
      end
    endcase
  end

  // Clear beats a same-edge increment.
  always_comb begin
    w_count_nxt = r_count;
    if (bus.i_clr) begin
      w_count_nxt = 16'h0000;
    end else if (w_inc) begin
      w_count_nxt = f_bcd_inc(r_count);
    end
  end

  always_ff @(posedge clk or negedge r_n) begin
    if (!r_n) begin
      r_state      <= S_IDLE;
      r_hcnt       <= '0;
      r_press      <= 1'b0;
      r_release    <= 1'b0;
      r_long_press <= 1'b0;
      r_rpt        <= 1'b0;
      r_held       <= 1'b0;
      r_is_long    <= 1'b0;
      r_count      <= 16'h0000;
    end else begin
      r_state      <= w_state_nxt;
      r_hcnt       <= w_hcnt_nxt;
      r_press      <= w_press_nxt;
      r_release    <= w_release_nxt;
      r_long_press <= w_long_nxt;
      r_rpt        <= w_rpt_nxt;
      // Status flags are registered from the next state so they line up
      // with the state register and stay glitch-free.
      r_held       <= (w_state_nxt != S_IDLE);
      r_is_long    <= (w_state_nxt == S_LONG);
      r_count      <= w_count_nxt;
    end
  end

  assign bus.o_press      = r_press;
  assign bus.o_release    = r_release;
  assign bus.o_long_press = r_long_press;
  assign bus.o_rpt        = r_rpt;
  assign bus.o_held       = r_held;
  assign bus.o_is_long    = r_is_long;
  assign bus.o_count      = r_count;

endmodule
`default_nettype wire

// File: tb/tb_btn_event.sv
`default_nettype none
// ============================================================================
//  Module      : tb_btn_event
//  Description : Self-checking bench for btn_event (LONG_CYCLES=8,
//                REPEAT_CYCLES=4). A behavioural model tracks the number of
//                cycles since the press edge and a decimal event count; a
//                compare process checks every output on each falling clock
//                edge, and directed sequences pin exact pulse positions and
//                BCD counts with literal expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_btn_event;

  localparam int L = 8;
  localparam int R = 4;

  logic clk = 1'b0;
  logic r_n;

  btn_event_if ifc ();

  btn_event #(
    .LONG_CYCLES   (L),
    .REPEAT_CYCLES (R)
  ) dut (
    .clk (clk),
    .r_n (r_n),
    .bus (ifc)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // m_t = number of edges since the press edge E0 (0 right after E0).
  bit m_held    = 1'b0;
  int m_t       = 0;
  int m_cnt     = 0;
  bit e_press   = 1'b0;
  bit e_release = 1'b0;
  bit e_long    = 1'b0;
  bit e_rpt     = 1'b0;
  bit e_is_long = 1'b0;

  always @(posedge clk or negedge r_n) begin : model
    bit nh, np, nr, nl, nrp, inc;
    int nt, nc;
    if (!r_n) begin
      m_held <= 1'b0; m_t <= 0; m_cnt <= 0;
      e_press <= 1'b0; e_release <= 1'b0; e_long <= 1'b0; e_rpt <= 1'b0; e_is_long <= 1'b0;
    end else begin
      nh = m_held; nt = m_t; nc = m_cnt;
      np = 1'b0; nr = 1'b0; nl = 1'b0; nrp = 1'b0; inc = 1'b0;
      if (!m_held && ifc.i_in) begin
        nh = 1'b1; nt = 0; np = 1'b1; inc = 1'b1;
      end else if (m_held && !ifc.i_in) begin
        nh = 1'b0; nt = 0; nr = 1'b1;
      end else if (m_held) begin
        nt = m_t + 1;
        if (nt == L) nl = 1'b1;
        if (nt > L && ((nt - L) % R) == 0) begin nrp = 1'b1; inc = 1'b1; end
      end
      if (ifc.i_clr) nc = 0;
      else if (inc)  nc = (nc + 1) % 10000;
      m_held <= nh; m_t <= nt; m_cnt <= nc;
      e_press <= np; e_release <= nr; e_long <= nl; e_rpt <= nrp;
      e_is_long <= nh && (nt >= L);
    end
  end

  function automatic logic [15:0] to_bcd(input int v);
    return {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  always @(negedge clk) begin
    chk("m_press",   ifc.o_press,      e_press);
    chk("m_release", ifc.o_release,    e_release);
    chk("m_long",    ifc.o_long_press, e_long);
    chk("m_rpt",     ifc.o_rpt,        e_rpt);
    chk("m_held",    ifc.o_held,       m_held);
    chk("m_is_long", ifc.o_is_long,    e_is_long);
    chk("m_count",   ifc.o_count,      to_bcd(m_cnt));
  end

  // ---------------- stimulus helpers ----------------
  task automatic drv(input bit in_v, input bit clr_v);
    ifc.i_in  = in_v;
    ifc.i_clr = clr_v;
  endtask

  task automatic step(input bit in_v, input bit clr_v);
    @(negedge clk);
    drv(in_v, clr_v);
  endtask

  task automatic press_once();
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
  endtask

  task automatic clear_count();
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
  endtask

  initial begin
    int run;
    bit lvl;
    r_n = 1'b1;
    drv(1'b0, 1'b0);
    #2 r_n = 1'b0;
    #1;
    chk("rst_held",  ifc.o_held,    32'd0);
    chk("rst_press", ifc.o_press,   32'd0);
    chk("rst_count", ifc.o_count,   32'h0000);
    @(negedge clk);
    @(negedge clk);
    r_n = 1'b1;

    // Short press: high for 3 edges, then low.
    step(1'b1, 1'b0);
    @(negedge clk);
    chk("short_press", ifc.o_press, 32'd1);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    repeat (3) step(1'b0, 1'b0);
    chk("short_count", ifc.o_count, 32'h0001);

    // Long hold: high for 20 edges from E0.
    clear_count();
    step(1'b1, 1'b0);
    for (int k = 0; k <= 20; k++) begin
      @(negedge clk);
      chk("long_lp",  ifc.o_long_press, 32'((k == 8)));
      chk("long_rpt", ifc.o_rpt,        32'((k == 12) || (k == 16)));
      chk("long_rel", ifc.o_release,    32'((k == 20)));
      chk("long_isl", ifc.o_is_long,    32'((k >= 8) && (k < 20)));
      drv((k < 19), 1'b0);
    end
    chk("long_count", ifc.o_count, 32'h0003);

    // Release exactly on the long threshold edge.
    clear_count();
    step(1'b1, 1'b0);
    for (int k = 0; k <= 8; k++) begin
      @(negedge clk);
      chk("bnd_lp",  ifc.o_long_press, 32'd0);
      chk("bnd_isl", ifc.o_is_long,    32'd0);
      chk("bnd_rel", ifc.o_release,    32'((k == 8)));
      drv((k < 7), 1'b0);
    end
    chk("bnd_count", ifc.o_count, 32'h0001);

    // Clear colliding with a press edge, then clear while idle.
    step(1'b0, 1'b0);
    step(1'b1, 1'b1);
    @(negedge clk);
    chk("clr_press", ifc.o_press, 32'd1);
    chk("clr_count", ifc.o_count, 32'h0000);
    drv(1'b0, 1'b0);
    press_once();
    chk("clr_pre", ifc.o_count, 32'h0001);
    step(1'b0, 1'b1);
    @(negedge clk);
    chk("clr_idle", ifc.o_count, 32'h0000);
    drv(1'b0, 1'b0);

    // BCD carries and wrap.
    repeat (9) press_once();
    chk("bcd_0009", ifc.o_count, 32'h0009);
    press_once();
    chk("bcd_0010", ifc.o_count, 32'h0010);
    repeat (90) press_once();
    chk("bcd_0100", ifc.o_count, 32'h0100);
    repeat (9899) press_once();
    chk("bcd_9999", ifc.o_count, 32'h9999);
    press_once();
    chk("bcd_wrap", ifc.o_count, 32'h0000);

    // Asynchronous reset while in LONG, with in still high afterwards.
    repeat (12) step(1'b1, 1'b0);
    @(posedge clk);
    #1;
    chk("pre_rst_long", ifc.o_is_long, 32'd1);
    #1 r_n = 1'b0;
    #1;
    chk("arst_held",  ifc.o_held,    32'd0);
    chk("arst_long",  ifc.o_is_long, 32'd0);
    chk("arst_count", ifc.o_count,   32'h0000);
    @(negedge clk);
    r_n = 1'b1;
    @(negedge clk);
    chk("arst_repress", ifc.o_press, 32'd1);
    drv(1'b0, 1'b0);
    step(1'b0, 1'b0);

    // Randomised runs of held/released levels with occasional clears.
    lvl = 1'b0;
    run = 0;
    for (int i = 0; i < 4000; i++) begin
      if (run == 0) begin
        lvl = ~lvl;
        run = lvl ? int'($urandom_range(1, 30)) : int'($urandom_range(1, 6));
      end
      step(lvl, ($urandom_range(0, 15) == 0));
      run--;
      if (i == 2000) begin
        @(posedge clk);
        #3 r_n = 1'b0;
        #1;
        chk("rand_arst_count", ifc.o_count, 32'h0000);
        @(negedge clk);
        r_n = 1'b1;
      end
    end
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
